vec_bram_loader: RTL
====================

Name: vec_bram_loader

Overview:
- Writer side of the GEMM vector-BRAM interface. It fills the single-port vector BRAM (Wi/Xi memories) that the GEMM sequencer later reads.
- Accepts a narrow stream of DATA_WIDTH words with a valid/ready handshake and packs LANES words into one varraysize-wide vector.
- Writes each packed vector to consecutive BRAM addresses from start_addr to end_addr, then raises Done.

Parameters:
- DATA_WIDTH, 16, width of one lane/stream word.
- LANES, 100, words per vector; vector width is LANES*DATA_WIDTH (1600).
- ADDR_WIDTH, 7, BRAM address width.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- start_addr  input  ADDR_WIDTH  first BRAM address; sampled on the accepted start.
- end_addr  input  ADDR_WIDTH  last BRAM address, inclusive; sampled on the accepted start.
- in_valid  input  1  stream word present.
- in_data  input  DATA_WIDTH  stream word.
- in_ready  output  1  loader accepts in_data this cycle.
- address_a  output  ADDR_WIDTH  BRAM write address.
- wren_a  output  1  BRAM write enable, one-cycle pulse per vector.
- data_a  output  LANES*DATA_WIDTH  packed vector to the BRAM.
- busy  output  1  high in FILL or WRITE.
- vec_count  output  ADDR_WIDTH+1  number of vectors written in the current load.
- Done  output  1  sticky completion flag.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0, including wren_a, address_a, data_a, in_ready, busy, vec_count and Done. Lane counter is cleared.
- Reset mid-load: the load is aborted immediately and the partial vector is discarded. After reset release the block sits in IDLE.
- IDLE:
  - in_ready=0.
  - On start=1: latch start_addr and end_addr, address_a<=start_addr, lane<=0, vec_count<=0, Done<=0, go to FILL.
- FILL:
  - in_ready=1; busy=1.
  - A word is accepted when in_valid and in_ready are both high. The accepted word is stored into data_a[lane*DATA_WIDTH +: DATA_WIDTH], so lane 0 occupies the LSBs. lane then increments.
  - When the word is accepted at lane==LANES-1: lane<=0 and the state goes to WRITE.
  - Stalls (in_valid=0) are unbounded; nothing changes while stalled.
- WRITE (exactly one cycle):
  - wren_a=1, in_ready=0; address_a and data_a hold stable; vec_count increments.
  - If address_a==end_addr, go to DONE.
  - Otherwise address_a<=address_a+1 (modulo 2^ADDR_WIDTH, so 127 wraps to 0) and return to FILL.
- DONE:
  - Done=1 (sticky); busy=0; in_ready=0. address_a, data_a and vec_count hold.
  - start=1 re-enters FILL exactly as from IDLE and clears Done in the same edge.
- start asserted in FILL or WRITE is ignored.
- Latency:
  - The last word of a vector is accepted on edge N; wren_a is high during cycle N+1.
  - If that was the final vector, Done rises at edge N+2.
  - The next FILL starts accepting at edge N+2.
- Address range:
  - start_addr==end_addr gives exactly 1 vector.
  - start_addr>end_addr wraps through 127→0. For example, 126→1 writes 4 vectors: 126, 127, 0, 1.
  - The maximum is 128 vectors, when end_addr==start_addr-1 mod 128; vec_count is ADDR_WIDTH+1 bits to hold it.
- Words presented while in_ready=0 are not consumed; the source must hold them until accepted.
- wren_a is never high in two consecutive cycles.

Test Plan:
- Reset, then start with start_addr=5, end_addr=5, and feed 100 words of value i (lane index) with in_valid held high → one wren_a pulse at address 5 with data_a[16*i+:16]==i. Done rises 2 cycles after the 100th word; vec_count=1.
- start_addr=0, end_addr=3, with random in_valid gaps → 4 writes at addresses 0,1,2,3. in_ready is 0 in each WRITE cycle and no words are lost; Done=1 and vec_count=4.
- Wrap: start_addr=126, end_addr=1 → writes at 126, 127, 0, 1, then Done; vec_count=4.
- Pull reset low after 50 words of the second vector → all outputs 0 immediately and no further wren_a. After release, in_ready stays 0 until a new start.
- Pulse start in the middle of FILL → ignored, addresses unchanged. Pulse start in DONE with start_addr=10, end_addr=10 → Done drops at that edge and one new write occurs at address 10.
- Hold in_valid=1 continuously across WRITE → exactly 100 accepts per vector; wren_a is never asserted on back-to-back cycles.

Source files
------------

// File: rtl/vec_bram_loader_if.sv
// Stream-in / BRAM-out bundle for the vector BRAM loader.
// master = word source and BRAM observer, slave = the loader itself.
interface vec_bram_loader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 100,
   parameter int ADDR_WIDTH = 7
);
   logic                        in_valid;
   logic [DATA_WIDTH-1:0]       in_data;
   logic                        in_ready;
   logic [ADDR_WIDTH-1:0]       address_a;
   logic                        wren_a;
   logic [LANES*DATA_WIDTH-1:0] data_a;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  address_a,
      input  wren_a,
      input  data_a
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output address_a,
      output wren_a,
      output data_a
   );
endinterface

// File: rtl/vec_bram_loader.sv
// Packs LANES stream words into one wide vector and writes consecutive BRAM
// addresses from start_addr to end_addr (inclusive, wrapping), then flags Done.
module vec_bram_loader #(
   parameter int DATA_WIDTH = 16,
   parameter int LANES      = 100,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   vec_bram_loader_if.slave      bus,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   vec_count,
   output logic                  Done
);

   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int VEC_W  = LANES * DATA_WIDTH;

   localparam logic [LANE_W-1:0]   LANE_LAST = LANE_W'(LANES - 1);
   localparam logic [LANE_W-1:0]   LANE_ONE  = LANE_W'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0] VEC_ONE   = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WRITE,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   end_q, end_d;
   logic [VEC_W-1:0]        data_q, data_d;
   logic [ADDR_WIDTH:0]     vec_count_q, vec_count_d;
   logic                    done_q, done_d;

   logic                    in_ready_int;
   logic                    wren_int;
   logic                    busy_int;
   logic                    start_ok;
   logic                    accept;
   logic                    last_lane;
   logic                    at_end;

   assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign accept    = bus.in_valid && in_ready_int;
   assign last_lane = (lane_q == LANE_LAST);
   assign at_end    = (addr_q == end_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = S_FILL;
         S_FILL:  if (accept && last_lane) state_d = S_WRITE;
         S_WRITE: state_d = at_end ? S_DONE : S_FILL;
         S_DONE:  if (start_ok) state_d = S_FILL;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready_int = 1'b0;
      wren_int     = 1'b0;
      busy_int     = 1'b0;
      case (state_q)
         S_FILL: begin
            in_ready_int = 1'b1;
            busy_int     = 1'b1;
         end
         S_WRITE: begin
            wren_int = 1'b1;
            busy_int = 1'b1;
         end
         default: ;
      endcase
   end

   // Done is set one cycle after entering DONE, so it rises two edges after the last word.
   always_comb begin
      lane_d      = lane_q;
      addr_d      = addr_q;
      end_d       = end_q;
      data_d      = data_q;
      vec_count_d = vec_count_q;
      done_d      = done_q;
      if (start_ok) begin
         addr_d      = start_addr;
         end_d       = end_addr;
         lane_d      = '0;
         vec_count_d = '0;
         done_d      = 1'b0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (accept) begin
                  data_d[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
                  lane_d = last_lane ? '0 : lane_q + LANE_ONE;
               end
            end
            S_WRITE: begin
               vec_count_d = vec_count_q + VEC_ONE;
               if (!at_end) addr_d = addr_q + ADDR_ONE;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_q      <= '0;
         addr_q      <= '0;
         end_q       <= '0;
         data_q      <= '0;
         vec_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         addr_q      <= addr_d;
         end_q       <= end_d;
         data_q      <= data_d;
         vec_count_q <= vec_count_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_int;
   assign bus.wren_a    = wren_int;
   assign bus.address_a = addr_q;
   assign bus.data_a    = data_q;
   assign busy          = busy_int;
   assign vec_count     = vec_count_q;
   assign Done          = done_q;

endmodule
